// File: rtl/serial_subtractor_pkg.sv
// Shared arithmetic-datapath types: serial FSM states and bit-counter sizing.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Counter must be able to hold the value WIDTH itself, not just WIDTH-1.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  localparam int DEFAULT_WIDTH = 4;
  localparam int CNT_W         = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result valid-ready bundle for the bit-serial subtractor.
interface serial_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] D;
  logic             Bout;
  logic             OVF;

  modport master (
    output in_valid, A, B, Bin, out_ready,
    input  in_ready, out_valid, D, Bout, OVF
  );

  modport slave (
    input  in_valid, A, B, Bin, out_ready,
    output in_ready, out_valid, D, Bout, OVF
  );
endinterface

// File: rtl/serial_subtractor_cell.sv
// One-bit full subtractor: d = a - b - br, combinational, no state.
module full_subtractor_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_br,
  output logic o_d,
  output logic o_br_next
);
  assign o_d       = i_a ^ i_b ^ i_br;
  assign o_br_next = (~i_a & i_b) | (~(i_a ^ i_b) & i_br);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial D = A - B - Bin, LSB first; result valid WIDTH+1 cycles after accept, held until out_ready.
// Optional signed-overflow flag enabled by SERIAL_SUBTRACTOR_OVF_EN; OVF reads 0 otherwise.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  serial_subtractor_if.slave bus
);
  localparam int CW = cnt_width(WIDTH);

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_d;
  logic             r_bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic             r_a_sign;
  logic             r_b_sign;
  logic             r_ovf;
`endif

  logic w_d;
  logic w_br_next;

  full_subtractor_cell u_cell (
    .i_a       (r_a_sr[0]),
    .i_b       (r_b_sr[0]),
    .i_br      (r_borrow),
    .o_d       (w_d),
    .o_br_next (w_br_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_a_sr      <= '0;
      r_b_sr      <= '0;
      r_diff      <= '0;
      r_borrow    <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_d         <= '0;
      r_bout      <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      r_a_sign    <= 1'b0;
      r_b_sign    <= 1'b0;
      r_ovf       <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_in_ready <= 1'b1;
          // Accept only when the registered ready is already visible outside.
          if (bus.in_valid && r_in_ready) begin
            r_a_sr     <= bus.A;
            r_b_sr     <= bus.B;
            r_borrow   <= bus.Bin;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= SHIFT;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            r_a_sign   <= bus.A[WIDTH-1];
            r_b_sign   <= bus.B[WIDTH-1];
`endif
          end
        end
        SHIFT: begin
          if (r_cnt != CW'(WIDTH)) begin
            r_diff   <= {w_d, r_diff[WIDTH-1:1]};
            r_a_sr   <= r_a_sr >> 1;
            r_b_sr   <= r_b_sr >> 1;
            r_borrow <= w_br_next;
            r_cnt    <= r_cnt + 1'b1;
          end else begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_d         <= r_diff;
            r_bout      <= r_borrow;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            r_ovf       <= (r_a_sign != r_b_sign) && (r_diff[WIDTH-1] != r_a_sign);
`endif
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.D         = r_d;
  assign bus.Bout      = r_bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  assign bus.OVF       = r_ovf;
`else
  assign bus.OVF       = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=4): directed cases, backpressure, ignore, reset abort, random.
module tb_serial_subtractor;
  localparam int W = 4;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  logic [W+1:0] exp_q[$];

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: {D, Bout, OVF} from plain wide arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    logic [W:0] t;
    logic       ovf;
    t   = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
    ovf = 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ovf = (a[W-1] != b[W-1]) && (t[W-1] != a[W-1]);
`endif
    return {t[W-1:0], t[W], ovf};
  endfunction

  // Result monitor: a handshake completes at the next rising edge.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", 32'd1, 32'd0);
      end else begin
        logic [W+1:0] e;
        e = exp_q.pop_front();
        chk("D", 32'(bus.D), 32'(e[W+1:2]));
        chk("Bout", 32'(bus.Bout), 32'(e[1]));
        chk("OVF", 32'(bus.OVF), 32'(e[0]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    int n;
    n = 0;
    while (!bus.in_ready && n < 60) begin
      tick();
      n++;
    end
    if (!bus.in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
    bus.in_valid = 1'b1;
    bus.A        = a;
    bus.B        = b;
    bus.Bin      = bin;
    @(posedge clk);
    exp_q.push_back(model(a, b, bin));
    #1;
    bus.in_valid = 1'b0;
    bus.A        = ~a;
    bus.B        = ~b;
    bus.Bin      = ~bin;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && bus.in_ready) && n < 100) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int k;
    int seen;
    logic [W+1:0] e;
    n_cmp = 0;
    n_bad = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.Bin       = 1'b0;
    bus.out_ready = 1'b0;

    tick();
    tick();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_D", 32'(bus.D), 32'd0);
    chk("rst_Bout", 32'(bus.Bout), 32'd0);
    chk("rst_OVF", 32'(bus.OVF), 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_in_ready", 32'(bus.in_ready), 32'd1);

    // First result arrives five edges after the accept edge.
    bus.out_ready = 1'b1;
    send(4'b1010, 4'b0011, 1'b0);
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus.out_valid) begin
        k = i;
        break;
      end
    end
    chk("latency", 32'(k), 32'd5);
    drain();

    send(4'b0001, 4'b1100, 1'b0);
    send(4'b1000, 4'b0001, 1'b0);
    send(4'b0000, 4'b0000, 1'b1);
    drain();

    // Backpressure: result and flags held, no new operand accepted.
    bus.out_ready = 1'b0;
    send(4'b0110, 4'b0010, 1'b1);
    e = model(4'b0110, 4'b0010, 1'b1);
    k = 0;
    while (!bus.out_valid && k < 30) begin
      tick();
      k++;
    end
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_D", 32'(bus.D), 32'(e[W+1:2]));
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    chk("bp_valid_drop", 32'(bus.out_valid), 32'd0);
    chk("bp_idle_ready", 32'(bus.in_ready), 32'd1);
    chk("bp_popped", 32'(exp_q.size()), 32'd0);

    // in_valid pulse during SHIFT must not disturb the operation.
    send(4'b0101, 4'b0011, 1'b0);
    tick();
    chk("shift_in_ready", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b1;
    bus.A        = 4'b1111;
    bus.B        = 4'b1111;
    bus.Bin      = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    drain();
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.out_valid) seen++;
    end
    chk("no_spurious", 32'(seen), 32'd0);

    // Reset on the second SHIFT edge discards the operation.
    send(4'b1100, 4'b0001, 1'b1);
    void'(exp_q.pop_back());
    tick();
    rst = 1'b1;
    tick();
    chk("abort_in_ready", 32'(bus.in_ready), 32'd0);
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_D", 32'(bus.D), 32'd0);
    chk("abort_Bout", 32'(bus.Bout), 32'd0);
    chk("abort_OVF", 32'(bus.OVF), 32'd0);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.out_valid) seen++;
    end
    chk("abort_no_valid", 32'(seen), 32'd0);
    chk("abort_ready", 32'(bus.in_ready), 32'd1);

    // Random operands with occasional result stalls.
    for (int i = 0; i < 24; i++) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      send(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      for (int j = 0; j < 8; j++) tick();
      bus.out_ready = 1'b1;
    end
    drain();
    chk("final_queue", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
